div_sched: RTL and testbench

Round-robin scheduler that shares one multi-cycle restoring divider among `N_REQ` requesters. It accepts one division request at a time over per-requester valid/ready handshakes and issues it to the divider with a start pulse. It waits for the divider's done pulse, then returns quotient, remainder and requester ID on a single valid/ready response channel. It sits between client datapaths and the shared divider instance.

---
 rtl/div_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/div_sched.sv | 151 +++++++++++++++
 tb/tb_div_sched.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and defaults for the divider scheduler
// Purpose: default widths and the scheduler FSM state type, imported by
//          div_sched and rr_arbiter.
// Ports:   none (package).
package div_pkg;

  localparam int DEFAULT_BIT_SIZE = 16;
  localparam int DEFAULT_N_REQ    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } div_sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
// Purpose: grants the first set request bit at or after ptr, wrapping
//          modulo N_REQ.
// Ports:   req       - request vector
//          ptr       - round-robin start index
//          grant     - one-hot grant (all zero when nothing requests)
//          grant_idx - encoded index of the granted requester
//          grant_any - at least one request was granted
module rr_arbiter
  import div_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_any
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    // Walk the requesters starting at ptr; the first hit wins and later
    // hits are masked by grant_any.
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_any && req[(int'(ptr) + i) % N_REQ]) begin
        grant[(int'(ptr) + i) % N_REQ] = 1'b1;
        grant_idx = ID_W'((int'(ptr) + i) % N_REQ);
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_sched.sv
// rtl/div_sched.sv - round-robin scheduler for one shared multi-cycle divider
// Purpose: accepts one request at a time from N_REQ requesters, issues it to
//          the divider with a start pulse, waits for done and returns the
//          result tagged with the requester ID.
// Optional feature: define DIV_ZERO_BYPASS_EN to answer divide-by-zero
//          requests locally (quotient all ones, remainder = dividend,
//          rsp_dbz = 1) without starting the divider.
// Ports:   clk, reset (async, active-high)
//          req_valid/req_ready           - per-requester handshake
//          req_dividend/req_divisor      - packed operands, BIT_SIZE each
//          div_start                     - one-cycle divider start pulse
//          div_dividend/div_divisor      - operands held until div_done
//          div_done                      - divider result strobe
//          div_quotient/div_remainder    - divider results
//          rsp_valid/rsp_ready           - response handshake
//          rsp_id/rsp_quotient/rsp_remainder/rsp_dbz - response payload
module div_sched
  import div_pkg::*;
#(
  parameter int N_REQ    = DEFAULT_N_REQ,
  parameter int BIT_SIZE = DEFAULT_BIT_SIZE,
  parameter int ID_W     = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*BIT_SIZE-1:0] req_dividend,
  input  logic [N_REQ*BIT_SIZE-1:0] req_divisor,
  output logic                      div_start,
  output logic [BIT_SIZE-1:0]       div_dividend,
  output logic [BIT_SIZE-1:0]       div_divisor,
  input  logic                      div_done,
  input  logic [BIT_SIZE-1:0]       div_quotient,
  input  logic [BIT_SIZE-1:0]       div_remainder,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [BIT_SIZE-1:0]       rsp_quotient,
  output logic [BIT_SIZE-1:0]       rsp_remainder,
  output logic                      rsp_dbz
);

  div_sched_state_t    state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     cur_id;
  logic [BIT_SIZE-1:0] op_dividend;
  logic [BIT_SIZE-1:0] op_divisor;
  logic [BIT_SIZE-1:0] res_quotient;
  logic [BIT_SIZE-1:0] res_remainder;

  logic [N_REQ-1:0]    grant;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_any;
  logic [BIT_SIZE-1:0] sel_dividend;
  logic [BIT_SIZE-1:0] sel_divisor;
  logic [ID_W-1:0]     next_ptr;

`ifdef DIV_ZERO_BYPASS_EN
  logic                dbz_q;
`endif

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign sel_dividend = req_dividend[int'(grant_idx)*BIT_SIZE +: BIT_SIZE];
  assign sel_divisor  = req_divisor[int'(grant_idx)*BIT_SIZE +: BIT_SIZE];

  // Pointer moves just past the requester that was served.
  assign next_ptr = (cur_id == ID_W'(N_REQ - 1)) ? '0 : cur_id + ID_W'(1);

  // req_ready is gated by reset as well so every output reads 0 while the
  // block is held in reset, even with requesters still asserting valid.
  assign req_ready     = (state == ST_IDLE && !reset) ? grant : '0;
  assign div_start     = (state == ST_ISSUE);
  assign div_dividend  = op_dividend;
  assign div_divisor   = op_divisor;
  assign rsp_valid     = (state == ST_RESP);
  assign rsp_id        = cur_id;
  assign rsp_quotient  = res_quotient;
  assign rsp_remainder = res_remainder;

`ifdef DIV_ZERO_BYPASS_EN
  assign rsp_dbz = dbz_q;
`else
  assign rsp_dbz = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      cur_id        <= '0;
      op_dividend   <= '0;
      op_divisor    <= '0;
      res_quotient  <= '0;
      res_remainder <= '0;
`ifdef DIV_ZERO_BYPASS_EN
      dbz_q         <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            op_dividend <= sel_dividend;
            op_divisor  <= sel_divisor;
            cur_id      <= grant_idx;
`ifdef DIV_ZERO_BYPASS_EN
            if (sel_divisor == '0) begin
              // Answer locally; the divider is never started.
              res_quotient  <= '1;
              res_remainder <= sel_dividend;
              dbz_q         <= 1'b1;
              state         <= ST_RESP;
            end else begin
              dbz_q <= 1'b0;
              state <= ST_ISSUE;
            end
`else
            state <= ST_ISSUE;
`endif
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (div_done) begin
            res_quotient  <= div_quotient;
            res_remainder <= div_remainder;
            state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rr_ptr <= next_ptr;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// tb/tb_div_sched.sv - scoreboard bench for div_sched with a behavioural divider
module tb_div_sched;

  localparam int N  = 4;
  localparam int B  = 16;
  localparam int IW = 2;
`ifdef DIV_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*B-1:0] req_dividend = '0;
  logic [N*B-1:0] req_divisor = '0;
  logic           div_start;
  logic [B-1:0]   div_dividend, div_divisor;
  logic           model_done = 1'b0;
  logic           stray_done = 1'b0;
  wire logic      div_done = model_done | stray_done;
  logic [B-1:0]   div_quotient = '0, div_remainder = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [IW-1:0]  rsp_id;
  logic [B-1:0]   rsp_quotient, rsp_remainder;
  logic           rsp_dbz;

  div_sched #(.N_REQ(N), .BIT_SIZE(B)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_dbz(rsp_dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [B-1:0] a;
    logic [B-1:0] b;
    logic [B-1:0] q;
    logic [B-1:0] r;
    logic       dbz;
  } exp_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] pend [N][$];
  exp_t        exp_q [$];
  int          grant_log [$];
  logic [N-1:0] acc_mask = '0;
  int          ptr = 0;
  bit          busy = 0;
  bit          cur_byp = 0;
  int          acc_cyc = 0;
  int          cur_lat = 16;
  bit          lat_rand = 0;
  bit          drop_mode = 0;
  int          rdy_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Divider reference: quotient/remainder D cycles after the start pulse.
  int           dcnt = 0;
  logic [B-1:0] da, db;
  always @(negedge clk) begin
    model_done = 1'b0;
    if (reset) begin
      dcnt = 0;
    end else if (div_start) begin
      da = div_dividend;
      db = div_divisor;
      dcnt = cur_lat;
    end else if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) model_done = 1'b1;
    end
    if (model_done) begin
      div_quotient  = (db == 0) ? '1 : da / db;
      div_remainder = (db == 0) ? da : da % db;
    end else begin
      div_quotient  = B'($urandom);
      div_remainder = B'($urandom);
    end
  end

  // Monitor and scoreboard: round-robin grant model, issue/response timing.
  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    int gid;
    exp_t e;
    cyc++;
    if (reset) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_div_start", div_start, 0);
      chk("rst_div_ops", {div_dividend, div_divisor}, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", {rsp_id, rsp_quotient, rsp_remainder, rsp_dbz}, 0);
      busy = 0;
      ptr = 0;
      exp_q.delete();
      acc_mask = '0;
    end else begin
      exp_ready = '0;
      gid = -1;
      if (!busy)
        for (int k = 0; k < N; k++)
          if (gid < 0 && req_valid[(ptr + k) % N]) gid = (ptr + k) % N;
      if (gid >= 0) exp_ready[gid] = 1'b1;
      chk("req_ready", req_ready, exp_ready);
      acc_mask = req_valid & req_ready;
      if (gid >= 0) begin
        for (int k = 0; k < N; k++) if (req_ready[k]) grant_log.push_back(k);
        e.id = gid;
        e.a = req_dividend[gid*B +: B];
        e.b = req_divisor[gid*B +: B];
        e.q = (e.b == 0) ? '1 : e.a / e.b;
        e.r = (e.b == 0) ? e.a : e.a % e.b;
        e.dbz = BYP && (e.b == 0);
        exp_q.push_back(e);
        busy = 1;
        acc_cyc = cyc;
        cur_byp = e.dbz;
        cur_lat = lat_rand ? int'($urandom_range(1, 12)) : 16;
      end
      chk("div_start", div_start, busy && !cur_byp && cyc == acc_cyc + 1);
      if (div_start && exp_q.size() > 0)
        chk("div_ops", {div_dividend, div_divisor}, {exp_q[0].a, exp_q[0].b});
      chk("rsp_valid", rsp_valid,
          busy && cyc >= acc_cyc + (cur_byp ? 1 : 2 + cur_lat));
      if (rsp_valid && exp_q.size() > 0) begin
        chk("rsp_id", rsp_id, exp_q[0].id);
        chk("rsp_quotient", rsp_quotient, exp_q[0].q);
        chk("rsp_remainder", rsp_remainder, exp_q[0].r);
        chk("rsp_dbz", rsp_dbz, exp_q[0].dbz);
      end
      if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
        ptr = (exp_q[0].id + 1) % N;
        void'(exp_q.pop_front());
        busy = 0;
      end
    end
  end

  task automatic apply();
    for (int i = 0; i < N; i++)
      if (acc_mask[i] && pend[i].size() > 0) void'(pend[i].pop_front());
    for (int i = 0; i < N; i++) begin
      if (pend[i].size() > 0) begin
        req_valid[i] = drop_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        req_dividend[i*B +: B] = pend[i][0][31:16];
        req_divisor[i*B +: B]  = pend[i][0][15:0];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
    case (rdy_mode)
      0: rsp_ready = 1'b1;
      1: rsp_ready = 1'($urandom_range(0, 1));
      default: rsp_ready = 1'b0;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    apply();
  endtask

  function automatic bit any_pend();
    for (int i = 0; i < N; i++) if (pend[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input int limit);
    int k = 0;
    step();
    while ((busy || any_pend()) && k < limit) begin
      step();
      k++;
    end
    chk("drain_in_time", k < limit, 1);
  endtask

  initial begin
    int k;
    int exp_order [5];
    repeat (3) step();
    reset = 1'b0;
    step();

    // All four requesters continuously valid, two operations each.
    grant_log.delete();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 2; j++)
        pend[i].push_back({16'(1000 + 37*i + j), 16'(3 + i + 2*j)});
    drain(400);
    exp_order = '{0, 1, 2, 3, 0};
    chk("grant_log_len", grant_log.size() >= 5, 1);
    if (grant_log.size() >= 5)
      for (int j = 0; j < 5; j++) chk("grant_order", grant_log[j], exp_order[j]);

    // Single request 100/7 from requester 2, D = 16.
    pend[2].push_back({16'd100, 16'd7});
    drain(100);

    // Backpressure: response held for 10 cycles.
    pend[1].push_back({16'd5000, 16'd33});
    pend[3].push_back({16'd777, 16'd5});
    rdy_mode = 2;
    k = 0;
    while (!rsp_valid && k < 100) begin
      step();
      k++;
    end
    chk("bp_rsp_seen", rsp_valid, 1);
    repeat (10) step();
    rdy_mode = 0;
    drain(100);

    // Divide by zero.
    pend[0].push_back({16'd55, 16'd0});
    drain(100);

    // Reset during WAIT, then a stray done, then the scan restarts at 0.
    pend[1].push_back({16'd900, 16'd9});
    drain(100);
    pend[3].push_back({16'd1234, 16'd11});
    k = 0;
    while (!(busy && cyc > acc_cyc + 5) && k < 100) begin
      step();
      k++;
    end
    chk("reached_wait", busy, 1);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    step();
    chk("stray_no_capture", {rsp_quotient, rsp_remainder, rsp_valid}, 0);
    grant_log.delete();
    pend[1].push_back({16'd4321, 16'd10});
    pend[3].push_back({16'd8765, 16'd43});
    drain(200);
    chk("post_reset_first", grant_log.size() > 0 ? grant_log[0] : -1, 1);

    // Randomized traffic: drops, random latency, random backpressure.
    drop_mode = 1;
    rdy_mode = 1;
    lat_rand = 1;
    k = 0;
    for (int n = 0; n < 6000 && k < 250; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        logic [15:0] a, b;
        a = 16'($urandom);
        case ($urandom_range(0, 9))
          0: b = 16'd0;
          1, 2, 3: b = 16'($urandom_range(1, 15));
          default: b = 16'($urandom_range(1, 65535));
        endcase
        pend[$urandom_range(0, N-1)].push_back({a, b});
        k++;
      end
      step();
    end
    drop_mode = 0;
    drain(8000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
